// File: rtl/sine_table_loader.sv
// sine_table_loader: port-0 writer for the NCO's 256x16 dual-port sine RAM.
// Assembles little-endian 16-bit samples from a valid/ready byte stream and
// writes them to consecutive RAM addresses starting at 0. The NCO keeps
// reading port 1 while the table is reloaded.
// Optional feature: define LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (modulo-256 sum of all data bytes) and report a mismatch on o_err.

module sine_table_loader #(
    parameter int WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_csb0,
    output logic [7:0]  o_addr0,
    output logic [15:0] o_din0,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [7:0] LAST_ADDR = 8'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WR   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK  = 3'd4,
`endif
        ST_DONE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_addr0;
    logic [7:0]  w_addr_next;
    logic [15:0] r_din0;
    logic [15:0] w_din_next;
    logic        r_byte_ready;
    logic        w_ready_next;
    logic        r_csb0;
    logic        r_busy;
    logic        r_done;
    logic        w_accept;
    logic        w_active;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    logic [7:0]  w_sum_next;
    logic        r_err;
    logic        w_err_next;
`endif

    assign w_accept = i_byte_valid & r_byte_ready;
    assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);

    // Next state and next datapath values for the load sequence.
    always_comb begin
        // NOTE: every target gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_addr_next  = r_addr0;
        w_din_next   = r_din0;
`ifdef LOADER_CHECKSUM_EN
        w_sum_next   = r_sum;
        w_err_next   = r_err;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next = ST_LO;
                    w_addr_next  = 8'd0;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_next   = 8'd0;
                    w_err_next   = 1'b0;
`endif
                end
            end
            ST_LO: begin
                if (w_accept) begin
                    w_din_next[7:0] = i_byte_in;
                    w_state_next    = ST_HI;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_next      = r_sum + i_byte_in;
`endif
                end
            end
            ST_HI: begin
                if (w_accept) begin
                    w_din_next[15:8] = i_byte_in;
                    w_state_next     = ST_WR;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_next       = r_sum + i_byte_in;
`endif
                end
            end
            ST_WR: begin
                // The last address holds (no wrap past 255) until the next start.
                if (r_addr0 == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = ST_CHK;
`else
                    w_state_next = ST_DONE;
`endif
                end else begin
                    w_addr_next  = r_addr0 + 8'd1;
                    w_state_next = ST_LO;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) begin
                    w_err_next   = (i_byte_in != r_sum);
                    w_state_next = ST_DONE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort cancels any in-progress load; words already written stay in RAM.
        if (i_abort && w_active) begin
            w_state_next = ST_IDLE;
            w_addr_next  = 8'd0;
        end

        w_ready_next = (w_state_next == ST_LO) || (w_state_next == ST_HI);
`ifdef LOADER_CHECKSUM_EN
        if (w_state_next == ST_CHK) begin
            w_ready_next = 1'b1;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output flops, decoded from the next state so every output is registered.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_addr0      <= 8'd0;
            r_din0       <= 16'd0;
            r_byte_ready <= 1'b0;
            r_csb0       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum        <= 8'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_addr0      <= w_addr_next;
            r_din0       <= w_din_next;
            r_byte_ready <= w_ready_next;
            r_csb0       <= (w_state_next != ST_WR);
            r_busy       <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
            r_done       <= (w_state_next == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
            r_sum        <= w_sum_next;
            r_err        <= w_err_next;
`endif
        end
    end

    // The RAM captures on the edge that ends the WR cycle, so abort or reset
    // raised during WR must mask the chip select within that same cycle.
    assign o_csb0       = r_csb0 | i_abort | i_rst;
    assign o_byte_ready = r_byte_ready;
    assign o_addr0      = r_addr0;
    assign o_din0       = r_din0;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

endmodule
